// File: rtl/mem_sequencer.sv
// mem_sequencer: LOAD/PLAY sequencer for the 16x8 packet memory.
// Sole driver of the memory address and write enable.
module mem_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic [AW-1:0] load_len,
  input  logic          in_valid,
  input  logic          run_start,
  input  logic [3:0]    run_reps,
  input  logic          abort,
  input  logic          pkt_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write_mode,
  output logic          pkt_valid,
  output logic          pkt_last,
  output logic          busy,
  output logic          loaded
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_len_q;
  logic [3:0]    r_rep_cnt;
  logic [3:0]    r_reps_q;
  logic          r_loaded;

  state_t        w_state_nxt;
  logic [AW-1:0] w_wr_nxt;
  logic [AW-1:0] w_rd_nxt;
  logic [AW-1:0] w_len_nxt;
  logic [3:0]    w_rep_nxt;
  logic [3:0]    w_reps_nxt;
  logic          w_loaded_nxt;

  logic          w_rd_end;
  logic          w_rep_end;
  logic          w_hs;
  logic [AW-1:0] w_wr_inc;
  logic [AW-1:0] w_rd_inc;

  assign w_rd_end  = (r_rd_ptr == r_len_q);
  assign w_rep_end = (r_rep_cnt == r_reps_q);
  assign w_hs      = pkt_valid & pkt_ready;

  // Pointers wrap at the memory depth
  assign w_wr_inc = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_inc = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;

  assign busy   = (r_state != S_IDLE);
  assign loaded = r_loaded;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_len_q   <= '0;
      r_rep_cnt <= '0;
      r_reps_q  <= '0;
      r_loaded  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_nxt;
      r_rd_ptr  <= w_rd_nxt;
      r_len_q   <= w_len_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_reps_q  <= w_reps_nxt;
      r_loaded  <= w_loaded_nxt;
    end
  end

  // Next-state, next-datapath and memory/stream outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_nxt       = r_wr_ptr;
    w_rd_nxt       = r_rd_ptr;
    w_len_nxt      = r_len_q;
    w_rep_nxt      = r_rep_cnt;
    w_reps_nxt     = r_reps_q;
    w_loaded_nxt   = r_loaded;
    mem_addr       = '0;
    mem_write_mode = 1'b0;
    pkt_valid      = 1'b0;
    pkt_last       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt  = S_LOAD;
          w_len_nxt    = load_len;
          w_wr_nxt     = '0;
          w_loaded_nxt = 1'b0;
        end else if (run_start && r_loaded) begin
          w_state_nxt = S_PLAY;
          w_reps_nxt  = run_reps;
          w_rd_nxt    = '0;
          w_rep_nxt   = '0;
        end
      end
      S_LOAD: begin
        mem_addr       = r_wr_ptr;
        mem_write_mode = in_valid;
        if (in_valid) begin
          w_wr_nxt = w_wr_inc;
          if (r_wr_ptr == r_len_q) begin
            w_state_nxt  = S_IDLE;
            w_loaded_nxt = 1'b1;
          end
        end
      end
      S_PLAY: begin
        mem_addr  = r_rd_ptr;
        pkt_valid = 1'b1;
        pkt_last  = w_rd_end & w_rep_end;
        if (w_hs) begin
          if (!w_rd_end) begin
            w_rd_nxt = w_rd_inc;
          end else if (!w_rep_end) begin
            w_rd_nxt  = '0;
            w_rep_nxt = r_rep_cnt + 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything; a partial load stays invalid
    if (abort) begin
      w_state_nxt    = S_IDLE;
      mem_write_mode = 1'b0;
      w_wr_nxt       = r_wr_ptr;
      w_rd_nxt       = r_rd_ptr;
      w_rep_nxt      = r_rep_cnt;
      if (r_state == S_LOAD) begin
        w_loaded_nxt = 1'b0;
      end
    end
  end

endmodule
